// File: rtl/ct_spsram_shade_pkg.sv
// Shared types and taint-merge helpers for the parametrised shadow-tainted SPSRAM.
// Contents:
//   state_e          - sequencer state (INIT clears the arrays, READY serves accesses)
//   wr_taint_bit     - taint value written into one shadow bit on a write access
//   wr_taint_mask_n  - active-low write enable for one shadow bit on a write access
//   rd_taint_any     - control-path taint that smears over a whole read word
package ct_spsram_shade_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

    // Enabled data bits take the full merged taint. A disabled data bit whose enable was
    // itself tainted might have been written, so its shadow bit is forced to 1.
    function automatic logic wr_taint_bit(input logic wen, input logic d_t0,
                                          input logic wen_t0, input logic gwen_t0,
                                          input logic cen_t0, input logic a_t0_any);
        if (!wen) begin
            return d_t0 | wen_t0 | gwen_t0 | cen_t0 | a_t0_any;
        end
        return 1'b1;
    endfunction

    // Shadow bit is written when its data bit is written, or when the data bit's
    // enable path carries taint.
    function automatic logic wr_taint_mask_n(input logic wen, input logic wen_t0,
                                             input logic gwen_t0, input logic cen_t0);
        return wen & ~(wen_t0 | gwen_t0 | cen_t0);
    endfunction

    function automatic logic rd_taint_any(input logic a_t0_any, input logic gwen_t0,
                                          input logic cen_t0);
        return a_t0_any | gwen_t0 | cen_t0;
    endfunction

endpackage

// File: rtl/ct_spsram_shade_array.sv
// Behavioural single-port DEPTH x DATA_WIDTH array, used for both data and taint.
// Ports:
//   clk     - clock
//   addr    - row address shared by the write and the read
//   wdata   - write data
//   wmask_n - per-bit write enable, active low (all ones = no write)
//   rdata   - asynchronous read of the addressed row
module ct_spsram_shade_array #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 59
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] wmask_n,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        mem[addr] <= (mem[addr] & wmask_n) | (wdata & ~wmask_n);
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ct_spsram_param_shade.sv
// Parametrised single-port SRAM with a bit-granular taint shadow and a post-reset
// clearing sequencer. Active-low CEN/GWEN/WEN interface.
// Ports:
//   CLK, RST          - clock, asynchronous active-high reset
//   A, A_t0           - address / address taint
//   CEN, CEN_t0       - chip enable (active low) / taint
//   GWEN, GWEN_t0     - global write enable (active low) / taint
//   WEN, WEN_t0       - per-bit write enable (active low) / taint
//   D, D_t0           - write data / data taint
//   Q, Q_t0           - read data / read taint (1 cycle, or 2 with OUT_REG=1)
//   INIT_BUSY         - high while the arrays are being cleared after reset
module ct_spsram_param_shade
    import ct_spsram_shade_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 59,
    parameter int unsigned OUT_REG    = 0,
    parameter int unsigned INIT_CLEAR = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [ADDR_WIDTH-1:0] A_t0,
    input  logic                  CEN,
    input  logic                  CEN_t0,
    input  logic                  GWEN,
    input  logic                  GWEN_t0,
    input  logic [DATA_WIDTH-1:0] WEN,
    input  logic [DATA_WIDTH-1:0] WEN_t0,
    input  logic [DATA_WIDTH-1:0] D,
    input  logic [DATA_WIDTH-1:0] D_t0,
    output logic [DATA_WIDTH-1:0] Q,
    output logic [DATA_WIDTH-1:0] Q_t0,
    output logic                  INIT_BUSY
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    // One extra counter bit keeps the terminal compare free of wrap ambiguity.
    localparam logic [ADDR_WIDTH:0] LAST_ROW = (ADDR_WIDTH + 1)'(DEPTH - 1);

    state_e                state_q;
    logic [ADDR_WIDTH:0]   cnt_q;
    logic                  init_busy_q;
    logic [DATA_WIDTH-1:0] q1_q;
    logic [DATA_WIDTH-1:0] q1_t0_q;

    logic                  a_t0_any;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  idle_taint;
    logic                  stage_load;

    logic [ADDR_WIDTH-1:0] arr_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [DATA_WIDTH-1:0] d_wmask_n;
    logic [DATA_WIDTH-1:0] t_wdata;
    logic [DATA_WIDTH-1:0] t_wmask_n;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic [DATA_WIDTH-1:0] t_rdata;

    assign a_t0_any   = |A_t0;
    assign wr_acc     = (state_q == READY) && !CEN && !GWEN;
    assign rd_acc     = (state_q == READY) && !CEN && GWEN;
    // A deselected cycle with tainted CEN might really have been a read.
    assign idle_taint = (state_q == READY) && CEN && CEN_t0;
    assign stage_load = rd_acc || idle_taint;

    // Init sequencer owns both array ports; otherwise the port inputs drive them.
    always_comb begin
        arr_addr  = A;
        d_wdata   = D;
        d_wmask_n = '1;
        t_wdata   = '0;
        t_wmask_n = '1;
        if (state_q == INIT) begin
            arr_addr  = cnt_q[ADDR_WIDTH-1:0];
            d_wdata   = '0;
            d_wmask_n = {DATA_WIDTH{INIT_CLEAR == 0}};
            t_wmask_n = '0;
        end else if (wr_acc) begin
            d_wmask_n = WEN;
            for (int i = 0; i < DATA_WIDTH; i++) begin
                t_wdata[i]   = wr_taint_bit(WEN[i], D_t0[i], WEN_t0[i], GWEN_t0, CEN_t0,
                                            a_t0_any);
                t_wmask_n[i] = wr_taint_mask_n(WEN[i], WEN_t0[i], GWEN_t0, CEN_t0);
            end
        end
    end

    ct_spsram_shade_array #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_data (
        .clk    (CLK),
        .addr   (arr_addr),
        .wdata  (d_wdata),
        .wmask_n(d_wmask_n),
        .rdata  (d_rdata)
    );

    ct_spsram_shade_array #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_taint (
        .clk    (CLK),
        .addr   (arr_addr),
        .wdata  (t_wdata),
        .wmask_n(t_wmask_n),
        .rdata  (t_rdata)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            init_busy_q <= 1'b1;
            q1_q        <= '0;
            q1_t0_q     <= '0;
        end else begin
            case (state_q)
                INIT: begin
                    q1_q    <= '0;
                    q1_t0_q <= '0;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST_ROW) begin
                        state_q     <= READY;
                        init_busy_q <= 1'b0;
                    end
                end
                READY: begin
                    if (rd_acc) begin
                        q1_q    <= d_rdata;
                        q1_t0_q <= t_rdata |
                                   {DATA_WIDTH{rd_taint_any(a_t0_any, GWEN_t0, CEN_t0)}};
                    end else if (idle_taint) begin
                        q1_t0_q <= '1;
                    end
                end
                default: state_q <= INIT;
            endcase
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic                  ld_q;
        logic [DATA_WIDTH-1:0] q2_q;
        logic [DATA_WIDTH-1:0] q2_t0_q;

        // Second stage only advances behind a first-stage load, so it holds otherwise.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                ld_q    <= 1'b0;
                q2_q    <= '0;
                q2_t0_q <= '0;
            end else begin
                ld_q <= stage_load;
                if (state_q == INIT) begin
                    q2_q    <= '0;
                    q2_t0_q <= '0;
                end else if (ld_q) begin
                    q2_q    <= q1_q;
                    q2_t0_q <= q1_t0_q;
                end
            end
        end

        assign Q    = q2_q;
        assign Q_t0 = q2_t0_q;
    end else begin : g_no_out_reg
        assign Q    = q1_q;
        assign Q_t0 = q1_t0_q;
    end

    assign INIT_BUSY = init_busy_q;

endmodule

// File: doc/ct_spsram_param_shade.md
# ct_spsram_param_shade

Parametrised single-port SRAM with a bit-granular taint shadow array and a post-reset clearing sequencer. It replaces the fixed-geometry spsram wrappers (256x59 and siblings) in caches and predictor tables, and returns a real stored taint on Q_t0 instead of a constant zero. The SRAM interface is the existing active-low CEN/GWEN/WEN convention, so call sites swap over without edits.

## Interface
- ADDR_WIDTH, 8, address bits; DEPTH = 2**ADDR_WIDTH rows
- DATA_WIDTH, 59, data and bit-write-enable width
- OUT_REG, 0, 1 adds an output register stage
- INIT_CLEAR, 1, 1 zeroes the data array during init; the taint array is always zeroed
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- A / A_t0  in  ADDR_WIDTH  address / address taint
- CEN / CEN_t0  in  1  chip enable, active low / taint
- GWEN / GWEN_t0  in  1  global write enable, active low / taint
- WEN / WEN_t0  in  DATA_WIDTH  per-bit write enable, active low / taint
- D / D_t0  in  DATA_WIDTH  write data / data taint
- Q / Q_t0  out  DATA_WIDTH  read data / read taint
- INIT_BUSY  out  1  high while the clearing sequencer runs

## Operation
- FSM states: INIT and READY.
- RST forces INIT, with row counter = 0.
- INIT:
  - Writes row counter with all-zero taint, and zero data when INIT_CLEAR=1; counter increments each cycle.
  - At counter == DEPTH-1, moves to READY.
  - Port inputs are ignored; Q and Q_t0 hold 0.
- READY, access when CEN==0:
  - Write (GWEN==0): for each bit i with WEN[i]==0, mem[A][i] <= D[i] and tmem[A][i] <= D_t0[i] | WEN_t0[i] | GWEN_t0 | CEN_t0 | (|A_t0).
  - Bits with WEN[i]==1 keep their data. Their tmem bit is set to 1 if WEN_t0[i] | GWEN_t0 | CEN_t0, otherwise it is unchanged.
  - Read (GWEN==1): Q <= mem[A]; Q_t0 <= tmem[A] | {DATA_WIDTH{(|A_t0) | GWEN_t0 | CEN_t0}}.
- READY, CEN==1:
  - No access; Q holds its value.
  - If CEN_t0==1, Q_t0 <= all ones, because a read may have occurred.
- A write never changes Q or Q_t0.
- Address taint on a write taints only the addressed row; no other rows are affected (decided, documented limitation).

## Timing
- Reset values: INIT_BUSY=1, Q=0, Q_t0=0, FSM=INIT, counter=0.
- Init lasts exactly DEPTH cycles after RST falls. INIT_BUSY drops on the clock edge that writes row DEPTH-1.
- The first access is accepted on the first edge with INIT_BUSY==0.
- Read latency: 1 cycle for OUT_REG=0; 2 cycles for OUT_REG=1.
  - With OUT_REG=1, the extra stage holds when no read is in flight.
  - CEN_t0-induced taint takes the same path and the same latency.
- Read in the cycle after a write to the same address returns the new data and taint. No bypass is needed because the array write completes at the edge.
- RST asserted mid-init or mid-read: immediate return to reset values; init restarts from row 0.
- Counter width is ADDR_WIDTH+1 so the terminal compare has no wrap ambiguity at DEPTH-1.

## Structure
- Package ct_spsram_shade_pkg:
  - State enum {INIT, READY}.
  - Function merging write taint (per the Operation equation).
  - Function merging read taint.
- Sub-module ct_spsram_shade_array: behavioural DEPTH x DATA_WIDTH array with active-low bit mask and a synchronous write port.
  - Instantiated twice, once for data and once for taint.
  - The init write port is muxed in front of each instance.
- Top level holds the FSM, row counter, input muxing and output registers.

## Test plan
- Reset then idle, DEPTH=256 -> INIT_BUSY high for exactly 256 cycles. With INIT_CLEAR=1, reading A=0x00 and A=0xFF afterwards gives Q=0, Q_t0=0.
- Write A=0x12, D=all ones, WEN=0, all taints 0; read 0x12 the next cycle -> Q=all ones, Q_t0=0 after 1 cycle (2 with OUT_REG=1).
- Write A=0x05, D_t0=bit3, WEN[58:32]=1; read 0x05 -> only bit3 tainted in Q_t0, and Q[58:32] equals the prior contents.
- Read A=0x05 with A_t0=0x01 -> Q_t0=all ones. Then CEN=1, CEN_t0=1 -> Q unchanged, Q_t0=all ones.
- Write with WEN[7]=1, WEN_t0[7]=1 at A=0x20, then read 0x20 -> data bit7 unchanged, Q_t0[7]=1.
- Assert RST at counter=100 -> outputs return to 0 and INIT_BUSY stays high for a full DEPTH cycles after release.
